// File: rtl/ad7643_emu_pkg.sv
// Shared types and defaults for the AD7643 serial-slave emulator.
`timescale 1ns/1ps
package ad7643_emu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2
    } state_e;

    localparam int DATA_W_DEF      = 18;
    localparam int CONV_CYCLES_DEF = 80;
    localparam int SAMPLE_CNT_W    = 16;

endpackage

// File: rtl/ad7643_serial_emulator_if.sv
// ADC readout link: controller drives CNVST/CS/SCLK, emulator returns BUSY/SYNC/SDOUT.
`timescale 1ns/1ps
interface ad7643_serial_emulator_if;
    logic ADCNVST;
    logic ADCS;
    logic ADSCLK;
    logic ADBUSY;
    logic ADSYNC;
    logic ADSDOUT;

    modport master (output ADCNVST, ADCS, ADSCLK, input ADBUSY, ADSYNC, ADSDOUT);
    modport slave  (input ADCNVST, ADCS, ADSCLK, output ADBUSY, ADSYNC, ADSDOUT);
endinterface

// File: rtl/ad7643_serial_emulator_sync_edge_det.sv
// Two-flop synchronizer with registered rise/fall pulses aligned to the synchronized level.
`timescale 1ns/1ps
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q;
    logic s2_q;
    logic rise_q;
    logic fall_q;

    // Pulses compare the value s2 is about to take (s1) with its current value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            rise_q <= s1_q & ~s2_q;
            fall_q <= s2_q & ~s1_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/ad7643_serial_emulator.sv
// AD7643 serial-slave emulator: conversion timing, sample source selection and MSB-first shift-out.
`timescale 1ns/1ps
module ad7643_serial_emulator
    import ad7643_emu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CONV_CYCLES = CONV_CYCLES_DEF,
    parameter int RAMP_STEP   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    ad7643_serial_emulator_if.slave adc,
    input  logic                    RAMP_EN,
    input  logic [DATA_W-1:0]       SAMPLE_IN,
    output logic                    FRAME_DONE,
    output logic                    OVR,
    output logic [SAMPLE_CNT_W-1:0] SAMPLE_CNT
);
    localparam int CNT_W = $clog2(CONV_CYCLES);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] STEP_L   = DATA_W'(RAMP_STEP);
    localparam logic [CNT_W-1:0]  CONV_TOP = CNT_W'(CONV_CYCLES - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    logic cnv_fall_s, sclk_fall_s, cs_level_s;
    logic cnv_level_unused_s, cnv_rise_unused_s;
    logic cs_rise_unused_s, cs_fall_unused_s;
    logic sclk_level_unused_s, sclk_rise_unused_s;

    sync_edge_det u_cnv (.clk(CLK), .rst(RST), .async_i(adc.ADCNVST),
        .level_o(cnv_level_unused_s), .rise_o(cnv_rise_unused_s), .fall_o(cnv_fall_s));
    sync_edge_det u_cs (.clk(CLK), .rst(RST), .async_i(adc.ADCS),
        .level_o(cs_level_s), .rise_o(cs_rise_unused_s), .fall_o(cs_fall_unused_s));
    sync_edge_det u_sclk (.clk(CLK), .rst(RST), .async_i(adc.ADSCLK),
        .level_o(sclk_level_unused_s), .rise_o(sclk_rise_unused_s), .fall_o(sclk_fall_s));

    state_e                  state_q;
    logic [CNT_W-1:0]        conv_cnt_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [DATA_W-1:0]       shreg_q;
    logic [DATA_W-1:0]       ramp_q;
    logic [SAMPLE_CNT_W-1:0] sample_cnt_q;
    logic busy_q, sync_q, sdout_q, frame_done_q, ovr_q;
    logic [DATA_W-1:0]       sample_sel_s;
    logic [DATA_W-1:0]       ramp_next_s;

    // Word captured at conversion start and the ramp value that follows it.
    always_comb begin
        sample_sel_s = RAMP_EN ? ramp_q : SAMPLE_IN;
        ramp_next_s  = RAMP_EN ? (ramp_q + STEP_L) : ramp_q;
    end

    // Conversion/shift FSM; a CNVST fall in SHIFT drops the frame and restarts in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            conv_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            ramp_q       <= '0;
            sample_cnt_q <= '0;
            busy_q       <= 1'b0;
            sync_q       <= 1'b0;
            sdout_q      <= 1'b0;
            frame_done_q <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            ovr_q        <= 1'b0;
            case (state_q)
                IDLE, SHIFT: begin
                    if (cnv_fall_s) begin
                        ovr_q      <= (state_q == SHIFT);
                        state_q    <= CONV;
                        busy_q     <= 1'b1;
                        sync_q     <= 1'b0;
                        sdout_q    <= 1'b0;
                        conv_cnt_q <= CONV_TOP;
                        bit_cnt_q  <= '0;
                        shreg_q    <= sample_sel_s;
                        ramp_q     <= ramp_next_s;
                    end else if ((state_q == SHIFT) && sclk_fall_s && !cs_level_s) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q      <= IDLE;
                            sync_q       <= 1'b0;
                            sdout_q      <= 1'b0;
                            frame_done_q <= 1'b1;
                            bit_cnt_q    <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                            sdout_q   <= shreg_q[DATA_W-2];
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                CONV: begin
                    if (conv_cnt_q == '0) begin
                        state_q      <= SHIFT;
                        busy_q       <= 1'b0;
                        sync_q       <= 1'b1;
                        sdout_q      <= shreg_q[DATA_W-1];
                        bit_cnt_q    <= '0;
                        sample_cnt_q <= sample_cnt_q + SAMPLE_CNT_W'(1);
                    end else begin
                        conv_cnt_q <= conv_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    sync_q  <= 1'b0;
                    sdout_q <= 1'b0;
                end
            endcase
        end
    end

    assign adc.ADBUSY  = busy_q;
    assign adc.ADSYNC  = sync_q;
    assign adc.ADSDOUT = sdout_q;
    assign FRAME_DONE  = frame_done_q;
    assign OVR         = ovr_q;
    assign SAMPLE_CNT  = sample_cnt_q;
endmodule
